vector_dac_arbiter: RTL and testbench

- Shares the X/Y 8-bit DAC channel pair between NREQ vector-point sources (e.g. static frame ROM, cursor, text overlay).
- Round-robin arbitration at object granularity. A granted source keeps the DAC until it delivers a point flagged last, or until it times out.
- Each accepted point is held on the DAC for DWELL cycles so the beam settles.
- Sits between the vector generators and the top-level xch/ych outputs, in the pclk (40 MHz) domain.

---
 rtl/vector_pkg.sv | 37 +++
 rtl/vector_dac_arbiter_rr_select.sv | 45 ++++
 rtl/vector_dac_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_vector_dac_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// -----------------------------------------------------------------------------
// vector_pkg
// Shared types and constants for the vector DAC arbiter slice.
//   point_t      : one vector point (X, Y, end-of-object flag)
//   arb_state_t  : arbiter FSM states (ARB, STREAM, HOLD)
//   DAC_W        : DAC code width
//   PARK_*_DEF   : default beam park position (screen centre)
//   cnt_width()  : width needed for the dwell/stall counters
// -----------------------------------------------------------------------------
package vector_pkg;

    localparam int DAC_W = 8;

    localparam logic [DAC_W-1:0] PARK_X_DEF = 8'd128;
    localparam logic [DAC_W-1:0] PARK_Y_DEF = 8'd128;

    typedef struct packed {
        logic [DAC_W-1:0] x;
        logic [DAC_W-1:0] y;
        logic             last;
    } point_t;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        STREAM = 2'd1,
        HOLD   = 2'd2
    } arb_state_t;

    // One counter width serves both the dwell and the stall counters, so it is
    // sized for the larger of the two terminal counts.
    function automatic int cnt_width(input int dwell, input int timeout);
        int m;
        m = (dwell > timeout) ? dwell : timeout;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/vector_dac_arbiter_rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
// Combinational cyclic priority picker: the first asserted request at or after
// the start pointer wins, wrapping from N-1 back to 0.
//   i_req     : request vector
//   i_start   : index searched first
//   o_onehot  : one-hot winner (zero when no request)
//   o_idx     : binary index of the winner (zero when no request)
//   o_any     : at least one request asserted
// -----------------------------------------------------------------------------
module rr_select #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Walk the requesters cyclically from i_start; the first hit latches o_any
    // so later candidates can no longer win.
    always_comb begin
        int                 w_sum;
        logic [IDX_W-1:0]   w_cand;
        logic               w_hit;
        o_onehot = {N{1'b0}};
        o_idx    = {IDX_W{1'b0}};
        o_any    = 1'b0;
        w_sum    = 0;
        w_cand   = {IDX_W{1'b0}};
        w_hit    = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_sum            = int'(i_start) + k;
            w_sum            = (w_sum >= N) ? (w_sum - N) : w_sum;
            w_cand           = IDX_W'(w_sum);
            w_hit            = !o_any && i_req[w_cand];
            o_onehot[w_cand] = o_onehot[w_cand] | w_hit;
            o_idx            = w_hit ? w_cand : o_idx;
            o_any            = o_any | w_hit;
        end
    end

endmodule

// File: rtl/vector_dac_arbiter.sv
// -----------------------------------------------------------------------------
// vector_dac_arbiter
// Shares one X/Y DAC pair between NREQ vector-point sources. Sources are
// granted round-robin per object; the owner streams points until one carries
// 'last' or it stalls for TIMEOUT cycles. Each accepted point is held on the
// DAC for DWELL cycles before the next one can be taken.
//   clk, rst      : pixel clock, asynchronous active-high reset
//   req_x/req_y   : packed per-requester coordinates (requester i at [8i+7:8i])
//   req_valid     : point offered by requester i
//   req_last      : offered point ends requester i's object
//   req_ready     : point accepted this cycle when valid & ready
//   xch/ych       : registered DAC codes
//   grant         : one-hot current owner, zero when none
//   timeout_err   : one-cycle pulse when a grant is revoked by stalling
// -----------------------------------------------------------------------------
module vector_dac_arbiter
    import vector_pkg::*;
#(
    parameter int               NREQ    = 4,
    parameter int               DWELL   = 16,
    parameter int               TIMEOUT = 1024,
    parameter logic [DAC_W-1:0] PARK_X  = PARK_X_DEF,
    parameter logic [DAC_W-1:0] PARK_Y  = PARK_Y_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ*DAC_W-1:0] req_x,
    input  logic [NREQ*DAC_W-1:0] req_y,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    output logic [DAC_W-1:0]      xch,
    output logic [DAC_W-1:0]      ych,
    output logic [NREQ-1:0]       grant,
    output logic                  timeout_err
);

    localparam int               IDX_W     = $clog2(NREQ);
    localparam int               CNT_W     = cnt_width(DWELL, TIMEOUT);
    localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NREQ - 1);

    arb_state_t         r_state,  w_state_n;
    logic [NREQ-1:0]    r_grant,  w_grant_n;
    logic [IDX_W-1:0]   r_gidx,   w_gidx_n;
    logic [IDX_W-1:0]   r_rr,     w_rr_n;
    point_t             r_pt,     w_pt_n;
    logic [CNT_W-1:0]   r_dwell,  w_dwell_n;
    logic [CNT_W-1:0]   r_stall,  w_stall_n;
    logic               r_terr,   w_terr_n;

    logic [NREQ-1:0]    w_pick;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_any;
    logic [DAC_W-1:0]   w_sel_x;
    logic [DAC_W-1:0]   w_sel_y;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic [IDX_W-1:0]   w_next_rr;

    rr_select #(
        .N     (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .i_req    (req_valid),
        .i_start  (r_rr),
        .o_onehot (w_pick),
        .o_idx    (w_pick_idx),
        .o_any    (w_any)
    );

    // Ready depends only on state and grant so a source can never see its own
    // valid loop back into ready.
    assign req_ready   = (r_state == STREAM) ? r_grant : {NREQ{1'b0}};
    assign xch         = r_pt.x;
    assign ych         = r_pt.y;
    assign grant       = r_grant;
    assign timeout_err = r_terr;

    // The pointer after a release always moves past the owner that just left.
    assign w_next_rr = (r_gidx == LAST_IDX) ? {IDX_W{1'b0}} : (r_gidx + IDX_W'(1'b1));

    // Route the granted requester's offer onto a single lane.
    always_comb begin
        w_sel_x     = {DAC_W{1'b0}};
        w_sel_y     = {DAC_W{1'b0}};
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            w_sel_x     = (r_gidx == IDX_W'(i)) ? req_x[i*DAC_W +: DAC_W] : w_sel_x;
            w_sel_y     = (r_gidx == IDX_W'(i)) ? req_y[i*DAC_W +: DAC_W] : w_sel_y;
            w_sel_valid = (r_gidx == IDX_W'(i)) ? req_valid[i]            : w_sel_valid;
            w_sel_last  = (r_gidx == IDX_W'(i)) ? req_last[i]             : w_sel_last;
        end
    end

    // Next-state, counter and output-register logic of the arbiter FSM.
    always_comb begin
        w_state_n = r_state;
        w_grant_n = r_grant;
        w_gidx_n  = r_gidx;
        w_rr_n    = r_rr;
        w_pt_n    = r_pt;
        w_dwell_n = r_dwell;
        w_stall_n = r_stall;
        w_terr_n  = 1'b0;
        case (r_state)
            ARB: begin
                if (w_any) begin
                    w_grant_n = w_pick;
                    w_gidx_n  = w_pick_idx;
                    w_stall_n = {CNT_W{1'b0}};
                    w_state_n = STREAM;
                end else begin
                    w_pt_n = {PARK_X, PARK_Y, 1'b0};
                end
            end
            STREAM: begin
                if (w_sel_valid) begin
                    w_pt_n    = {w_sel_x, w_sel_y, w_sel_last};
                    w_dwell_n = DWELL_LD;
                    w_stall_n = {CNT_W{1'b0}};
                    w_state_n = HOLD;
                end else if (r_stall == STALL_LIM) begin
                    // Stalled owner loses the DAC; the last point stays visible
                    // until the following ARB cycle parks it.
                    w_terr_n  = 1'b1;
                    w_grant_n = {NREQ{1'b0}};
                    w_rr_n    = w_next_rr;
                    w_stall_n = {CNT_W{1'b0}};
                    w_state_n = ARB;
                end else begin
                    w_stall_n = r_stall + CNT_W'(1'b1);
                end
            end
            HOLD: begin
                if (r_dwell == {CNT_W{1'b0}}) begin
                    if (r_pt.last) begin
                        w_grant_n = {NREQ{1'b0}};
                        w_rr_n    = w_next_rr;
                        w_state_n = ARB;
                    end else begin
                        w_state_n = STREAM;
                    end
                end else begin
                    w_dwell_n = r_dwell - CNT_W'(1'b1);
                end
            end
            default: begin
                w_grant_n = {NREQ{1'b0}};
                w_state_n = ARB;
            end
        endcase
    end

    // State and output registers; reset parks the beam immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB;
            r_grant <= {NREQ{1'b0}};
            r_gidx  <= {IDX_W{1'b0}};
            r_rr    <= {IDX_W{1'b0}};
            r_pt    <= {PARK_X, PARK_Y, 1'b0};
            r_dwell <= {CNT_W{1'b0}};
            r_stall <= {CNT_W{1'b0}};
            r_terr  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_grant <= w_grant_n;
            r_gidx  <= w_gidx_n;
            r_rr    <= w_rr_n;
            r_pt    <= w_pt_n;
            r_dwell <= w_dwell_n;
            r_stall <= w_stall_n;
            r_terr  <= w_terr_n;
        end
    end

endmodule

// File: tb/tb_vector_dac_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vector_dac_arbiter
// Self-checking bench: a behavioural model (owner / remaining-hold / stall
// counts) predicts every output each cycle; directed scenarios add literal
// expectations, then a randomized phase exercises arbitrary traffic.
// -----------------------------------------------------------------------------
module tb_vector_dac_arbiter;

    localparam int NREQ    = 4;
    localparam int DWELL   = 16;
    localparam int TIMEOUT = 1024;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ*8-1:0]   req_x;
    logic [NREQ*8-1:0]   req_y;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_last;
    logic [NREQ-1:0]     req_ready;
    logic [7:0]          xch;
    logic [7:0]          ych;
    logic [NREQ-1:0]     grant;
    logic                timeout_err;

    always #5 clk = ~clk;

    vector_dac_arbiter #(
        .NREQ    (NREQ),
        .DWELL   (DWELL),
        .TIMEOUT (TIMEOUT),
        .PARK_X  (8'd128),
        .PARK_Y  (8'd128)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .xch         (xch),
        .ych         (ych),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int acc_cyc = 0;

    // Behavioural model: owner (-1 = arbitrating), cycles of dwell left,
    // consecutive stalled cycles, next search start.
    int         m_owner;
    int         m_ptr;
    int         m_hold;
    int         m_stall;
    int         m_acc;
    logic [7:0] m_x;
    logic [7:0] m_y;
    logic       m_lastf;
    logic       m_terr;

    int              ready1_cnt  = 0;
    int              ready13_cnt = 0;
    logic [NREQ-1:0] prev_grant;
    logic [NREQ-1:0] grant_seq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_hold = 0; m_stall = 0; m_acc = -1;
        m_x = 8'd128; m_y = 8'd128; m_lastf = 1'b0; m_terr = 1'b0;
    endtask

    task automatic model_step();
        bit found;
        m_terr = 1'b0;
        m_acc  = -1;
        found  = 1'b0;
        if (rst) begin
            model_reset();
        end else if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (!found && req_valid[c]) begin
                    found = 1'b1; m_owner = c; m_stall = 0;
                end
            end
            if (!found) begin
                m_x = 8'd128; m_y = 8'd128;
            end
        end else if (m_hold == 0) begin
            if (req_valid[m_owner]) begin
                m_x = req_x[m_owner*8 +: 8];
                m_y = req_y[m_owner*8 +: 8];
                m_lastf = req_last[m_owner];
                m_hold = DWELL; m_stall = 0; m_acc = m_owner;
            end else begin
                m_stall++;
                if (m_stall == TIMEOUT) begin
                    m_terr = 1'b1; m_ptr = (m_owner + 1) % NREQ; m_owner = -1; m_stall = 0;
                end
            end
        end else begin
            m_hold--;
            if (m_hold == 0 && m_lastf) begin
                m_ptr = (m_owner + 1) % NREQ; m_owner = -1;
            end
        end
    endtask

    task automatic compare_all();
        logic [NREQ-1:0] eg;
        logic [NREQ-1:0] er;
        eg = (m_owner >= 0) ? NREQ'(1 << m_owner) : {NREQ{1'b0}};
        er = (m_owner >= 0 && m_hold == 0) ? eg : {NREQ{1'b0}};
        chk("xch",         32'(xch),         32'(m_x));
        chk("ych",         32'(ych),         32'(m_y));
        chk("grant",       32'(grant),       32'(eg));
        chk("req_ready",   32'(req_ready),   32'(er));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        if (req_ready[1]) ready1_cnt++;
        if (req_ready[1] | req_ready[3]) ready13_cnt++;
        if (grant != prev_grant && grant != {NREQ{1'b0}}) grant_seq.push_back(grant);
        prev_grant = grant;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_src(input int i, input logic v, input logic [7:0] x,
                           input logic [7:0] y, input logic l);
        req_valid[i]     = v;
        req_x[i*8 +: 8]  = x;
        req_y[i*8 +: 8]  = y;
        req_last[i]      = l;
    endtask

    // Offer one point from source i, wait until it is taken, then withdraw it
    // and check the DAC shows it one cycle after the accepting edge.
    task automatic send_point(input int i, input logic [7:0] x, input logic [7:0] y, input logic l);
        int n;
        set_src(i, 1'b1, x, y, l);
        n = 0;
        while (!(m_owner == i && m_hold == 0) && n < 3000) begin
            tick();
            n++;
        end
        chk("accept_wait", 32'(n < 3000), 32'd1);
        tick();
        acc_cyc = cyc;
        set_src(i, 1'b0, x, y, 1'b0);
        chk("dac_x_point", 32'(xch), 32'(x));
        chk("dac_y_point", 32'(ych), 32'(y));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int a0;
        int cnt0;
        int cnt2;
        int n;
        logic [NREQ-1:0] exp_seq [4];
        exp_seq = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};

        rst = 1'b1; req_x = '0; req_y = '0; req_valid = '0; req_last = '0;
        prev_grant = '0;
        model_reset();
        tick();
        tick();
        chk("rst_xch",   32'(xch),         32'd128);
        chk("rst_ych",   32'(ych),         32'd128);
        chk("rst_grant", 32'(grant),       32'd0);
        chk("rst_ready", 32'(req_ready),   32'd0);
        chk("rst_terr",  32'(timeout_err), 32'd0);
        rst = 1'b0;
        repeat (3) tick();

        // Three-point object from req0.
        send_point(0, 8'd10, 8'd20, 1'b0);
        a0 = acc_cyc;
        chk("obj0_grant", 32'(grant), 32'h1);
        send_point(0, 8'd30, 8'd40, 1'b0);
        chk("obj0_gap1", 32'(acc_cyc - a0), 32'(DWELL + 1));
        a0 = acc_cyc;
        send_point(0, 8'd50, 8'd60, 1'b1);
        chk("obj0_gap2", 32'(acc_cyc - a0), 32'(DWELL + 1));
        repeat (DWELL - 1) tick();
        chk("obj0_held_grant", 32'(grant), 32'h1);
        tick();
        chk("obj0_arb_grant", 32'(grant), 32'h0);
        chk("obj0_arb_xkept", 32'(xch),   32'd50);
        tick();
        chk("obj0_parked_x", 32'(xch), 32'd128);
        chk("obj0_parked_y", 32'(ych), 32'd128);

        // req0 and req2 both busy with 2-point objects; pointer now at 1.
        ready13_cnt = 0;
        grant_seq.delete();
        cnt0 = 0; cnt2 = 0; n = 0;
        while ((cnt0 + cnt2) < 8 && n < 600) begin
            set_src(0, 1'b1, 8'(cnt0),      8'(100 + cnt0), (cnt0 % 2) == 1);
            set_src(2, 1'b1, 8'(32 + cnt2), 8'(132 + cnt2), (cnt2 % 2) == 1);
            tick();
            n++;
            if (m_acc == 0) cnt0++;
            else if (m_acc == 2) cnt2++;
        end
        set_src(0, 1'b0, 8'd0, 8'd0, 1'b0);
        set_src(2, 1'b0, 8'd0, 8'd0, 1'b0);
        chk("alt_budget",   32'(n < 600),          32'd1);
        chk("alt_nobjects", 32'(grant_seq.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("alt_grant_seq", (k < grant_seq.size()) ? 32'(grant_seq[k]) : 32'hffff_ffff,
                32'(exp_seq[k]));
        end
        chk("alt_no_ready_1_3", 32'(ready13_cnt), 32'd0);
        repeat (DWELL + 2) tick();

        // Timeout: req3 stalls while req0 waits.
        do_reset();
        send_point(3, 8'd77, 8'd88, 1'b0);
        chk("to_grant3", 32'(grant), 32'h8);
        set_src(0, 1'b1, 8'd1, 8'd2, 1'b1);
        repeat (DWELL + TIMEOUT - 1) tick();
        chk("to_pre_err",   32'(timeout_err), 32'd0);
        chk("to_pre_grant", 32'(grant),       32'h8);
        tick();
        chk("to_err",        32'(timeout_err), 32'd1);
        chk("to_grant_clr",  32'(grant),       32'h0);
        chk("to_x_kept",     32'(xch),         32'd77);
        chk("to_y_kept",     32'(ych),         32'd88);
        tick();
        chk("to_err_pulse",  32'(timeout_err), 32'd0);
        chk("to_next_grant", 32'(grant),       32'h1);
        send_point(0, 8'd1, 8'd2, 1'b1);
        repeat (DWELL + 2) tick();

        // Single-point object on req1 with the pointer at 1.
        ready1_cnt = 0;
        send_point(1, 8'h5A, 8'hA5, 1'b1);
        repeat (DWELL - 1) tick();
        chk("single_held", 32'(grant), 32'h2);
        tick();
        chk("single_release", 32'(grant),      32'h0);
        chk("single_ready1",  32'(ready1_cnt), 32'd1);
        repeat (2) tick();

        // Pointer wrap: req3 finishes, then req0 beats req3.
        send_point(3, 8'd33, 8'd44, 1'b1);
        set_src(0, 1'b1, 8'd5, 8'd6, 1'b1);
        set_src(3, 1'b1, 8'd7, 8'd8, 1'b1);
        repeat (DWELL) tick();
        chk("wrap_arb",  32'(grant), 32'h0);
        tick();
        chk("wrap_req0", 32'(grant), 32'h1);
        send_point(0, 8'd5, 8'd6, 1'b1);
        send_point(3, 8'd7, 8'd8, 1'b1);
        repeat (DWELL + 2) tick();

        // Asynchronous reset in the middle of a hold.
        send_point(2, 8'd200, 8'd201, 1'b0);
        repeat (3) tick();
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_x",     32'(xch),       32'd128);
        chk("async_rst_y",     32'(ych),       32'd128);
        chk("async_rst_grant", 32'(grant),     32'h0);
        chk("async_rst_ready", 32'(req_ready), 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                set_src(i, $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
                        $urandom_range(0, 2) == 0);
            end
            tick();
        end
        req_valid = '0;
        req_last  = '0;
        repeat (DWELL + 4) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
